// File: rtl/rot_enc_conditioner.sv
// Rotary encoder front end: two-flop synchronisers and per-channel debounce
// on the raw A/B contacts, followed by a quadrature decoder that produces
// registered step/error pulses, a wrapping position and a saturating error
// count. Everything runs on CLK10K.
//
// Decoder transition classes ({prev A,B} -> {cur A,B}):
//   TR_NONE | no change in the debounced pair
//   TR_CW   | 00->01, 01->11, 11->10, 10->00 (STEP_UP, POS+1)
//   TR_CCW  | 00->10, 10->11, 11->01, 01->00 (STEP_DN, POS-1)
//   TR_ERR  | both bits changed at once (STEP_ERR, ERR_CNT+1 saturating)
module rot_enc_conditioner #(
  parameter int DB_CYCLES = 20,
  parameter int CNT_W     = 8
) (
  input  logic       CLK10K,
  input  logic       RSTN,
  input  logic       ROT_A_RAW,
  input  logic       ROT_B_RAW,
  input  logic       CLR,
  output logic       ROT_A,
  output logic       ROT_B,
  output logic       STEP_UP,
  output logic       STEP_DN,
  output logic       STEP_ERR,
  output logic [7:0] POS,
  output logic [3:0] ERR_CNT
);

  typedef enum logic [1:0] {
    TR_NONE,
    TR_CW,
    TR_CCW,
    TR_ERR
  } trans_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // Channel pairs are packed as {A, B}: index 1 is A, index 0 is B.
  logic [1:0]       s1_q;
  logic [1:0]       s2_q;
  logic [1:0]       lvl_q;
  logic [1:0]       lvl_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic [1:0]       prev_q;
  trans_e           trans;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             err_q, err_d;
  logic [7:0]       pos_q, pos_d;
  logic [3:0]       err_cnt_q, err_cnt_d;

  // Two-flop synchroniser per channel; idles high like an open contact.
  always_ff @(posedge CLK10K or negedge RSTN) begin
    if (!RSTN) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
    end else begin
      s1_q <= {ROT_A_RAW, ROT_B_RAW};
      s2_q <= s1_q;
    end
  end

  // Debounce: the level follows s2 only after DB_CYCLES consecutive
  // disagreeing cycles; any agreement restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge CLK10K or negedge RSTN) begin
    if (!RSTN) begin
      lvl_q    <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      lvl_q    <= lvl_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Classify the debounced pair change and compute counter updates.
  always_comb begin
    trans     = TR_NONE;
    up_d      = 1'b0;
    dn_d      = 1'b0;
    err_d     = 1'b0;
    pos_d     = pos_q;
    err_cnt_d = err_cnt_q;

    case ({prev_q, lvl_q})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: trans = TR_CW;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: trans = TR_CCW;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: trans = TR_ERR;
      default:                            trans = TR_NONE;
    endcase

    case (trans)
      TR_CW: begin
        up_d  = 1'b1;
        pos_d = pos_q + 8'd1;
      end
      TR_CCW: begin
        dn_d  = 1'b1;
        pos_d = pos_q - 8'd1;
      end
      TR_ERR: begin
        err_d = 1'b1;
        if (err_cnt_q != 4'hF) begin
          err_cnt_d = err_cnt_q + 4'd1;
        end
      end
      default: ;
    endcase

    // Clear wins over a same-cycle step or error, but pulses still fire.
    if (CLR) begin
      pos_d     = '0;
      err_cnt_d = '0;
    end
  end

  // Decoder registers: previous pair, pulse outputs and counters.
  always_ff @(posedge CLK10K or negedge RSTN) begin
    if (!RSTN) begin
      prev_q    <= 2'b11;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      err_q     <= 1'b0;
      pos_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      prev_q    <= lvl_q;
      up_q      <= up_d;
      dn_q      <= dn_d;
      err_q     <= err_d;
      pos_q     <= pos_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ROT_A    = lvl_q[1];
  assign ROT_B    = lvl_q[0];
  assign STEP_UP  = up_q;
  assign STEP_DN  = dn_q;
  assign STEP_ERR = err_q;
  assign POS      = pos_q;
  assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_rot_enc_conditioner.sv
// Testbench for rot_enc_conditioner: directed encoder waveforms with a
// scoreboard of expected step/error pulses checked by a separate monitor.
`timescale 1ns/1ps
module tb_rot_enc_conditioner;

  logic       CLK10K;
  logic       RSTN;
  logic       ROT_A_RAW;
  logic       ROT_B_RAW;
  logic       CLR;
  logic       ROT_A;
  logic       ROT_B;
  logic       STEP_UP;
  logic       STEP_DN;
  logic       STEP_ERR;
  logic [7:0] POS;
  logic [3:0] ERR_CNT;

  rot_enc_conditioner dut (
    .CLK10K    (CLK10K),
    .RSTN      (RSTN),
    .ROT_A_RAW (ROT_A_RAW),
    .ROT_B_RAW (ROT_B_RAW),
    .CLR       (CLR),
    .ROT_A     (ROT_A),
    .ROT_B     (ROT_B),
    .STEP_UP   (STEP_UP),
    .STEP_DN   (STEP_DN),
    .STEP_ERR  (STEP_ERR),
    .POS       (POS),
    .ERR_CNT   (ERR_CNT)
  );

  initial begin
    CLK10K = 1'b0;
    forever #50 CLK10K = ~CLK10K;
  end

  // Edge counter: edge 1 is the first rising edge after reset release.
  int cyc;
  always @(posedge CLK10K or negedge RSTN) begin
    if (!RSTN) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int a, input int b, input int pos, input int ec);
    chk({tag, "_rot_a"}, ROT_A, a);
    chk({tag, "_rot_b"}, ROT_B, b);
    chk({tag, "_pos"}, POS, pos);
    chk({tag, "_err_cnt"}, ERR_CNT, ec);
  endtask

  // Scoreboard: kind 1 = STEP_UP, 2 = STEP_DN, 3 = STEP_ERR; cyc < 0 = any.
  typedef struct {
    int kind;
    int pos;
    int err;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   exp_pos = 0;
  int   exp_err = 0;

  task automatic expect_step(input int kind, input int at_cyc);
    if (kind == 1) exp_pos = (exp_pos + 1) % 256;
    if (kind == 2) exp_pos = (exp_pos + 255) % 256;
    if (kind == 3 && exp_err < 15) exp_err++;
    sb_q.push_back('{kind, exp_pos, exp_err, at_cyc});
  endtask

  // Monitor: every pulse seen must match the head of the scoreboard.
  always @(negedge CLK10K) begin
    int   n;
    int   kind;
    exp_t e;
    if (RSTN === 1'b1 && (STEP_UP || STEP_DN || STEP_ERR)) begin
      n = int'(STEP_UP) + int'(STEP_DN) + int'(STEP_ERR);
      chk("pulse_exclusive", n, 1);
      kind = STEP_UP ? 1 : (STEP_DN ? 2 : 3);
      if (sb_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d expected none", kind, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_kind", kind, e.kind);
        chk("pulse_pos", POS, e.pos);
        chk("pulse_err_cnt", ERR_CNT, e.err);
        if (e.cyc >= 0) chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge CLK10K);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLK10K);
  endtask

  // One clockwise detent cycle 11->10->00->01->11.
  task automatic cw_step_b(input logic v);
    ROT_B_RAW = v;
    expect_step(1, -1);
    hold(40);
  endtask

  task automatic cw_step_a(input logic v);
    ROT_A_RAW = v;
    expect_step(1, -1);
    hold(40);
  endtask

  task automatic cw_cycle();
    cw_step_b(1'b0);
    cw_step_a(1'b0);
    cw_step_b(1'b1);
    cw_step_a(1'b1);
  endtask

  initial begin
    int c;
    int seen;
    RSTN      = 1'b0;
    ROT_A_RAW = 1'b1;
    ROT_B_RAW = 1'b1;
    CLR       = 1'b0;
    hold(3);
    chk_state("in_reset", 1, 1, 0, 0);
    RSTN = 1'b1;
    #1;
    chk_state("reset_release", 1, 1, 0, 0);
    wait_cyc(100);
    chk_state("idle100", 1, 1, 0, 0);

    // A falls before edge 110: level at edge 131, STEP_DN at edge 132.
    wait_cyc(109);
    ROT_A_RAW = 1'b0;
    expect_step(2, 132);
    wait_cyc(130);
    chk("a_before_latency", ROT_A, 1);
    wait_cyc(131);
    chk("a_at_latency", ROT_A, 0);
    wait_cyc(160);
    chk_state("a_fall", 0, 1, 255, 0);

    ROT_A_RAW = 1'b1;
    expect_step(1, -1);
    hold(40);
    chk_state("a_rise", 1, 1, 0, 0);

    // 19-cycle glitch must be swallowed.
    seen = 0;
    ROT_A_RAW = 1'b0;
    repeat (19) begin
      hold(1);
      if (ROT_A !== 1'b1) seen = 1;
    end
    ROT_A_RAW = 1'b1;
    repeat (40) begin
      hold(1);
      if (ROT_A !== 1'b1) seen = 1;
    end
    chk("glitch19_no_change", seen, 0);

    // 20-cycle glitch propagates, then the return propagates too.
    c = cyc;
    seen = 0;
    ROT_A_RAW = 1'b0;
    expect_step(2, c + 23);
    hold(20);
    ROT_A_RAW = 1'b1;
    expect_step(1, -1);
    repeat (40) begin
      hold(1);
      if (ROT_A === 1'b0) seen = 1;
    end
    chk("glitch20_fell", seen, 1);
    hold(10);
    chk_state("glitch20", 1, 1, 0, 0);

    cw_cycle();
    chk_state("cw1", 1, 1, 4, 0);
    repeat (63) cw_cycle();
    chk_state("cw64_wrap", 1, 1, 0, 0);

    // Double-bit changes count as errors and saturate.
    ROT_A_RAW = 1'b0;
    ROT_B_RAW = 1'b0;
    expect_step(3, -1);
    hold(40);
    chk_state("err1", 0, 0, 0, 1);
    ROT_A_RAW = 1'b1;
    ROT_B_RAW = 1'b1;
    expect_step(3, -1);
    hold(40);
    repeat (19) begin
      ROT_A_RAW = 1'b0;
      ROT_B_RAW = 1'b0;
      expect_step(3, -1);
      hold(40);
      ROT_A_RAW = 1'b1;
      ROT_B_RAW = 1'b1;
      expect_step(3, -1);
      hold(40);
    end
    chk_state("err_sat", 1, 1, 0, 15);

    // Walk POS to 7 ending at 01, then clear on the edge of the next step.
    cw_cycle();
    cw_step_b(1'b0);
    cw_step_a(1'b0);
    cw_step_b(1'b1);
    chk("pos7", POS, 7);
    c = cyc;
    ROT_A_RAW = 1'b1;
    sb_q.push_back('{1, 0, 0, c + 23});
    exp_pos = 0;
    exp_err = 0;
    wait_cyc(c + 22);
    CLR = 1'b1;
    hold(1);
    CLR = 1'b0;
    hold(10);
    chk_state("clr", 1, 1, 0, 0);

    // Reset in the middle of a debounce (counter at 10).
    ROT_A_RAW = 1'b0;
    expect_step(2, -1);
    hold(40);
    chk_state("pre_rst", 0, 1, 255, 0);
    c = cyc;
    ROT_A_RAW = 1'b1;
    wait_cyc(c + 12);
    RSTN = 1'b0;
    #1;
    chk_state("rst_mid", 1, 1, 0, 0);
    chk("rst_mid_pulses", {STEP_UP, STEP_DN, STEP_ERR}, 0);
    exp_pos = 0;
    exp_err = 0;
    hold(2);
    RSTN = 1'b1;
    hold(60);
    chk_state("post_rst", 1, 1, 0, 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #5000000;
    errs++;
    checks++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rot_enc_conditioner.md
Name: rot_enc_conditioner

Overview:
- Front-end conditioner for the rotary encoder's raw A/B contacts.
- Synchronises and debounces each channel, then presents clean levels to the downstream PWM brightness stage.
- Also decodes quadrature transitions into single-cycle step pulses, a wrapping position count and a saturating error count.
- Runs entirely in the CLK10K domain; one instance per encoder.

Parameters:
DB_CYCLES, 20, consecutive CLK10K cycles a synchronised input must differ from its debounced level before the level updates (2 ms at 10 kHz); legal range 1..255
CNT_W, 8, width of debounce counters (must hold DB_CYCLES-1)

Ports:
CLK10K  input  1  10 kHz system clock, all logic on rising edge
RSTN  input  1  asynchronous active-low reset
ROT_A_RAW  input  1  raw encoder contact A, asynchronous, bouncy
ROT_B_RAW  input  1  raw encoder contact B, asynchronous, bouncy
CLR  input  1  synchronous clear of POS and ERR_CNT
ROT_A  output  1  debounced A level, to downstream PWM stage
ROT_B  output  1  debounced B level, to downstream PWM stage
STEP_UP  output  1  one-cycle pulse per valid clockwise transition
STEP_DN  output  1  one-cycle pulse per valid counter-clockwise transition
STEP_ERR  output  1  one-cycle pulse when both debounced bits change in the same cycle
POS  output  8  step position, wraps modulo 256
ERR_CNT  output  4  count of STEP_ERR events, saturates at 15

Behaviour:
- Reset: RSTN is asynchronous, active-low; clock is CLK10K.
  - On reset: sync flops = 1, ROT_A = ROT_B = 1, debounce counters = 0, prev pair = 2'b11.
  - STEP_UP = STEP_DN = STEP_ERR = 0, POS = 0, ERR_CNT = 0.
  - An asserted reset mid-operation aborts any debounce in progress; no pulse is emitted on release.
- Synchroniser: two flops per channel (s1, s2).
- Debounce, per channel, evaluated every edge:
  - If s2 == debounced level: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: level <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any return of s2 to the current level before expiry clears cnt; bounces shorter than DB_CYCLES never propagate.
- Latency: raw input stable from before edge k -> debounced output changes at edge k+1+DB_CYCLES (k+21 at default).
  - With DB_CYCLES=1 the output changes at edge k+2.
- The A and B channels are fully independent; both may update on the same edge.
- Quadrature decoder: compares prev = {ROT_A,ROT_B} of the previous cycle with current {ROT_A,ROT_B}; prev <= current every edge.
  - CW transitions (00->01, 01->11, 11->10, 10->00): STEP_UP = 1 for exactly the next cycle; POS <= POS+1.
  - CCW transitions (00->10, 10->11, 11->01, 01->00): STEP_DN = 1; POS <= POS-1.
  - Double-bit change (00<->11, 01<->10): STEP_ERR = 1; ERR_CNT <= ERR_CNT+1 unless already 15; POS unchanged.
  - No change: all pulses 0.
  - Pulse outputs are registered and assert the cycle after the debounced change. STEP_UP, STEP_DN and STEP_ERR are mutually exclusive.
- POS arithmetic: 8-bit two's-complement wrap.
  - 255 + 1 -> 0.
  - 0 - 1 -> 255.
- CLR:
  - Forces POS = 0 and ERR_CNT = 0 on that edge, overriding any same-cycle step or error update.
  - Pulses still fire normally. Debounce and sync state are unaffected.
- Power-up with encoder resting at 00: after debounce both bits fall together, giving one STEP_ERR (ERR_CNT = 1). This is accepted behaviour; software clears with CLR.

Test Plan:
- Reset release with raw inputs held 1 for 100 cycles -> ROT_A = ROT_B = 1, no pulses, POS = 0, ERR_CNT = 0.
- A held 0 from edge 10 (B = 1) -> ROT_A falls at edge 31; STEP_DN high for one cycle at edge 32; POS = 255.
- A glitches 0 for 19 cycles then back to 1 -> ROT_A never changes; no pulses. Repeat with 20 cycles -> ROT_A changes.
- Full clockwise cycle 11->10->00->01->11, each phase held 40 cycles -> exactly 4 STEP_UP pulses, POS = 4, ERR_CNT = 0. Repeat 64 times -> POS wraps to 0.
- A and B both switched 1->0 on the same edge -> one STEP_ERR, ERR_CNT = 1, POS unchanged. Repeat 20 times -> ERR_CNT saturates at 15.
- CLR asserted on the same edge as a STEP_UP update with POS = 7 -> POS = 0 after the edge, STEP_UP pulse still seen. RSTN asserted mid-debounce (cnt = 10) -> all outputs at reset values immediately.
